// File: rtl/sd_rx_nibble_fifo.sv
// SD receive FIFO: packs 4-bit bus nibbles (wclk) into 32-bit words and hands them
// to the system clock domain (clk) as a first-word-fall-through queue.
module sd_rx_nibble_fifo #(
    parameter int BUS_W  = 4,
    parameter int WORD_W = 32,
    parameter int ADR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wclk,
    input  logic [BUS_W-1:0]  d,
    input  logic              wr,
    output logic              full,
    output logic              mem_empt,
    output logic [WORD_W-1:0] q,
    input  logic              rd,
    output logic              empty
);

    localparam int NIBS  = WORD_W / BUS_W;
    localparam int CNT_W = $clog2(NIBS);
    localparam int PTR_W = ADR_W + 1;
    localparam int DEPTH = 1 << ADR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // write (wclk) domain
    logic [WORD_W-BUS_W-1:0] asm_reg;
    logic [WORD_W-1:0]       asm_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [PTR_W-1:0]        wbin_reg, wbin_next;
    logic [PTR_W-1:0]        wgray_reg, wgray_next;
    logic [PTR_W-1:0]        rgray_s1_reg, rgray_s2_reg;
    logic                    full_reg, full_next;
    logic                    nib_acc, word_done;

    // read (clk) domain
    logic [PTR_W-1:0]        rbin_reg, rbin_next;
    logic [PTR_W-1:0]        rgray_reg, rgray_next;
    logic [PTR_W-1:0]        wgray_s1_reg, wgray_s2_reg;
    logic                    rd_acc;

    assign nib_acc   = wr & ~full_reg;
    assign word_done = nib_acc && (cnt_reg == CNT_W'(NIBS - 1));
    assign asm_next  = {asm_reg, d};
    assign wbin_next = wbin_reg + PTR_W'(word_done);

    assign empty     = (rgray_reg == wgray_s2_reg);
    assign rd_acc    = rd & ~empty;
    assign rbin_next = rbin_reg + PTR_W'(rd_acc);

    genvar gi;
    generate
        for (gi = 0; gi < PTR_W - 1; gi++) begin : g_gray
            assign wgray_next[gi] = wbin_next[gi] ^ wbin_next[gi+1];
            assign rgray_next[gi] = rbin_next[gi] ^ rbin_next[gi+1];
        end
    endgenerate
    assign wgray_next[PTR_W-1] = wbin_next[PTR_W-1];
    assign rgray_next[PTR_W-1] = rbin_next[PTR_W-1];

    // Full in Gray space: top two bits inverted, the rest equal to the synced read pointer.
    assign full_next = (wgray_next == {~rgray_s2_reg[PTR_W-1:PTR_W-2], rgray_s2_reg[PTR_W-3:0]});

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            asm_reg      <= '0;
            cnt_reg      <= '0;
            wbin_reg     <= '0;
            wgray_reg    <= '0;
            rgray_s1_reg <= '0;
            rgray_s2_reg <= '0;
            full_reg     <= 1'b0;
        end else begin
            if (nib_acc) begin
                asm_reg <= asm_next[WORD_W-BUS_W-1:0];
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            wbin_reg     <= wbin_next;
            wgray_reg    <= wgray_next;
            rgray_s1_reg <= rgray_reg;
            rgray_s2_reg <= rgray_s1_reg;
            full_reg     <= full_next;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge wclk) begin
        if (word_done) begin
            mem[wbin_reg[ADR_W-1:0]] <= asm_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin_reg     <= '0;
            rgray_reg    <= '0;
            wgray_s1_reg <= '0;
            wgray_s2_reg <= '0;
        end else begin
            rbin_reg     <= rbin_next;
            rgray_reg    <= rgray_next;
            wgray_s1_reg <= wgray_reg;
            wgray_s2_reg <= wgray_s1_reg;
        end
    end

    assign q        = mem[rbin_reg[ADR_W-1:0]];
    assign full     = full_reg;
    assign mem_empt = (wgray_reg == rgray_s2_reg);

endmodule

// File: tb/tb_sd_rx_nibble_fifo.sv
// Bench for sd_rx_nibble_fifo: vector table, hand sequences for the multi-cycle corners,
// and randomized streaming against a queue model of the word FIFO.
module tb_sd_rx_nibble_fifo;

    logic        clk = 1'b0;
    logic        wclk = 1'b0;
    logic        rst;
    logic [3:0]  d;
    logic        wr;
    logic        rd;
    logic        full, mem_empt, empty;
    logic [31:0] q;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] model_q [$];

    sd_rx_nibble_fifo #(.BUS_W(4), .WORD_W(32), .ADR_W(3)) dut (
        .clk(clk), .rst(rst), .wclk(wclk), .d(d), .wr(wr),
        .full(full), .mem_empt(mem_empt), .q(q), .rd(rd), .empty(empty)
    );

    always #10 clk = ~clk;              // 50 MHz
    initial begin
        #7;
        forever #20 wclk = ~wclk;       // 25 MHz, offset phase
    end

    typedef struct {
        logic [3:0]  nib [8];
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs [4];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic wr_nib(input logic [3:0] n);
        d  = n;
        wr = 1'b1;
        @(posedge wclk);
        #1;
        wr = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) wr_nib(w[31-4*i -: 4]);
    endtask

    task automatic wait_q(input string name, input logic [31:0] exp);
        int k = 0;
        @(negedge clk);
        while (empty && k < 4) begin
            @(negedge clk);
            k++;
        end
        chk({name, " nonempty"}, {31'd0, empty}, 32'd0);
        chk({name, " q"}, q, exp);
    endtask

    task automatic pop_one(input string name);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk({name, " empty after pop"}, {31'd0, empty}, 32'd1);
    endtask

    task automatic do_reset();
        wr  = 1'b0;
        rd  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_writer(input int n, input bit incr, input bit gaps);
        logic [31:0] val;
        for (int w = 0; w < n; w++) begin
            int b = 0;
            val = incr ? 32'(w) : $urandom;
            while (model_q.size() > 2 && b < 5000) begin
                @(posedge wclk);
                #1;
                b++;
            end
            if (b >= 5000) chk("writer throttle timeout", 32'd1, 32'd0);
            for (int i = 0; i < 8; i++) begin
                if (gaps && $urandom_range(3) == 0)
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge wclk);
                        #1;
                    end
                wr_nib(val[31-4*i -: 4]);
                chk("stream full", {31'd0, full}, 32'd0);
            end
            model_q.push_back(val);
        end
    endtask

    task automatic run_reader(input int rd_pct, input int n_words);
        int got = 0;
        int budget = 0;
        while (got < n_words && budget < 30000) begin
            @(negedge clk);
            rd = 1'b0;
            budget++;
            if (!empty) begin
                if (model_q.size() == 0) begin
                    chk("spurious word", {31'd0, empty}, 32'd1);
                end else if ($urandom_range(99) < rd_pct) begin
                    chk("stream q", q, model_q[0]);
                    void'(model_q.pop_front());
                    rd = 1'b1;
                    got++;
                end
            end else if ($urandom_range(3) == 0) begin
                rd = 1'b1;      // pop attempt while empty must be ignored
            end
        end
        @(negedge clk);
        rd = 1'b0;
        chk("reader word count", 32'(got), 32'(n_words));
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{'{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}, 32'h12345678};
        vecs[1] = '{'{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1}, 32'hABCDEF01};
        vecs[2] = '{'{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF}, 32'h0F0F0F0F};
        vecs[3] = '{'{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8}, 32'hFEDCBA98};

        d   = 4'h0;
        wr  = 1'b0;
        rd  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset empty", {31'd0, empty}, 32'd1);
        chk("reset full", {31'd0, full}, 32'd0);
        chk("reset mem_empt", {31'd0, mem_empt}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single-word vectors
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) wr_nib(vecs[v].nib[i]);
            wait_q($sformatf("vec%0d", v), vecs[v].exp_q);
            chk($sformatf("vec%0d mem_empt", v), {31'd0, mem_empt}, 32'd0);
            pop_one($sformatf("vec%0d", v));
            repeat (4) @(posedge wclk);
            #1;
            chk($sformatf("vec%0d mem_empt drained", v), {31'd0, mem_empt}, 32'd1);
        end

        // Partial word stays invisible until the 8th nibble
        for (int i = 0; i < 7; i++) wr_nib(4'(9 - i));
        repeat (6) @(negedge clk);
        chk("partial empty", {31'd0, empty}, 32'd1);
        wr_nib(4'h2);
        wait_q("partial done", 32'h98765432);
        pop_one("partial");

        // Fill to capacity, overflow nibbles dropped
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (k == 7 && j == 7) chk("full before last", {31'd0, full}, 32'd0);
                wr_nib(j == 0 ? 4'(k) : 4'(j));
            end
        end
        chk("full after 64", {31'd0, full}, 32'd1);
        chk("mem_empt when full", {31'd0, mem_empt}, 32'd0);
        for (int i = 0; i < 8; i++) wr_nib(4'hF);
        chk("full after drops", {31'd0, full}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("fill rd%0d nonempty", k), {31'd0, empty}, 32'd0);
            w = {4'(k), 28'h1234567};
            chk($sformatf("fill rd%0d q", k), q, w);
            rd = 1'b1;
        end
        @(negedge clk);
        rd = 1'b0;
        chk("fill drained empty", {31'd0, empty}, 32'd1);
        repeat (5) @(posedge wclk);
        #1;
        chk("full cleared", {31'd0, full}, 32'd0);
        for (int i = 0; i < 8; i++) wr_nib(4'(i == 0 ? 3 : (i == 1 ? 1 : (i == 2 ? 4 : (i == 3 ? 1 :
                                        (i == 4 ? 5 : (i == 5 ? 9 : (i == 6 ? 2 : 6))))))));
        wait_q("post-drop word", 32'h31415926);
        pop_one("post-drop");

        // Pointer wrap with alternating write/read
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            write_word(w);
            wait_q($sformatf("wrap%0d", k), w);
            pop_one($sformatf("wrap%0d", k));
        end

        // Reset mid-operation discards queued words and the partial word
        do_reset();
        write_word(32'h11111111);
        write_word(32'h22222222);
        write_word(32'h33333333);
        for (int i = 0; i < 5; i++) wr_nib(4'h7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst empty", {31'd0, empty}, 32'd1);
        chk("midrst full", {31'd0, full}, 32'd0);
        chk("midrst mem_empt", {31'd0, mem_empt}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("after rst still empty", {31'd0, empty}, 32'd1);
        write_word(32'hCAFEBABE);
        wait_q("after rst word", 32'hCAFEBABE);
        pop_one("after rst");

        // Continuous stream, reader pops every non-empty cycle
        do_reset();
        fork
            run_writer(100, 1'b1, 1'b0);
            run_reader(100, 100);
        join

        // Randomized data, gaps and read pacing
        do_reset();
        fork
            run_writer(150, 1'b0, 1'b1);
            run_reader(60, 150);
        join
        repeat (4) @(negedge clk);
        chk("final empty", {31'd0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
